uart_rcv_fc: RTL and testbench
==============================

Name: uart_rcv_fc

Overview:
- Full-featured UART receiver, 8N1, LSB first; the counterpart of the command transmitter (uart_tx).
- Sits inside Segway behind the RX pin. Deserialises BLE/host commands (e.g. 'g' = 0x67, 's' = 0x73) and hands bytes to the auth/command block through a rdy/clr_rdy handshake.
- Adds false-start rejection and framing-error detection.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); legal range 16..4095.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- RX  in  1  asynchronous serial input, idles high
- clr_rdy  in  1  consumer acknowledge; clears rdy
- rx_data  out  8  received byte, valid while rdy=1
- rdy  out  1  byte available
- frm_err  out  1  last frame had stop bit = 0

Behaviour:
- Reset values:
  - rdy=0, frm_err=0, rx_data=8'h00.
  - Synchroniser flops preset to 1; FSM in IDLE.
  - A reset mid-frame discards the partial byte.
- RX passes through a 2-flop synchroniser (rx_s). Falling-edge detect compares rx_s with its delayed copy. Total input latency is 3 clk.
- FSM states: IDLE, START, DATA, STOP, BRK.
  - IDLE: a falling edge on rx_s loads baud_cnt=BAUD_DIV/2 (integer floor), goes to START, clears rdy and frm_err.
  - START: when baud_cnt reaches 0, sample rx_s.
    - rx_s=1 is a false start: go to IDLE; rdy stays cleared.
    - rx_s=0: reload baud_cnt=BAUD_DIV-1, bit_cnt=0, go to DATA.
  - DATA: each time baud_cnt reaches 0, shift rx_s into the MSB of shift reg (right shift, so the first bit ends up in bit 0) and reload. After the 8th sample (bit_cnt==7), go to STOP.
  - STOP: at mid-stop sample:
    - rx_s=1: rx_data<=shift reg, rdy<=1, go to IDLE.
    - rx_s=0: rx_data unchanged, rdy stays 0, frm_err<=1, go to BRK.
  - BRK: wait until rx_s=1, then go to IDLE. A held-low line (break) never produces a byte.
- Counter widths: baud_cnt is 12-bit down-counter; bit_cnt is 3-bit.
- Output timing: rdy rises exactly 1 clk after the mid-stop sample edge. That is 9.5*BAUD_DIV + 4 clk (±1) after the RX falling edge.
- rdy/clr_rdy handshake:
  - rdy stays high until clr_rdy=1 or a new start bit is detected.
  - If clr_rdy and the rdy-set event occur in the same cycle, set wins.
  - rx_data is stable whenever rdy=1.
- frm_err holds until the next start-bit detect or clr_rdy.
- Back-to-back frames: the next falling edge is accepted in the first IDLE cycle after STOP. No idle gap is required beyond the stop bit.

Optional Feature:
- Macro: UART_RCV_OVERRUN_EN.
- When defined:
  - Adds output ovr_err (1 bit, reset 0).
  - Start-bit detect does NOT clear rdy.
  - If a valid stop completes while rdy=1 and clr_rdy=0: ovr_err<=1, rx_data is overwritten with the new byte, rdy stays 1.
  - ovr_err clears on clr_rdy.
- When undefined: port absent; rdy clears on start-bit detect as above.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BRK}.
  - localparam DEF_BAUD_DIV = 2604.
  - Command constants CMD_GO=8'h67 and CMD_STOP=8'h73, shared with uart_tx and the benches.
- One natural sub-module: rx_synch (2-flop synchroniser with preset-high, plus falling-edge output). It is reusable for other async inputs.

Test Plan:
- Transmit 0x67 via uart_tx at BAUD_DIV=2604 → rdy rises ~24,740 clk after start, rx_data=8'h67, frm_err=0.
- With rdy high, pulse clr_rdy 1 clk → rdy=0 next cycle and rx_data unchanged. Assert clr_rdy in the same cycle as a new byte completes → rdy=1.
- Drive RX low for 600 clk (< BAUD_DIV/2), then high → no rdy, no frm_err, FSM back in IDLE; a following 0x73 is received correctly.
- Frame 0x55 with stop bit forced 0, RX held low 5 bit times, then released → frm_err=1, rdy=0, rx_data keeps its old value; the next frame 0xA5 gives rdy=1, rx_data=8'hA5, frm_err=0.
- Back-to-back 0x67, 0x73 with no gap, clr_rdy never asserted → rdy stays low briefly at the 2nd start, then rx_data=8'h73. With UART_RCV_OVERRUN_EN: rdy stays 1, ovr_err=1, rx_data=8'h73.
- rst_n low for 2 clk during DATA bit 4 of 0x67 → all outputs reset; the next clean 0x67 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver, transmitter and benches.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    localparam int DEF_BAUD_DIV = 2604;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/rx_synch.sv
// Two-flop synchroniser, preset high, with a falling-edge strobe.
// Reusable for any asynchronous input that idles high.
module rx_synch (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= 3'b111;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign dout = sr[1];
    assign fall = sr[2] & ~sr[1];

endmodule

// File: rtl/uart_rcv_fc.sv
// 8N1 UART receiver with false-start rejection and framing-error flag.
// Define UART_RCV_OVERRUN_EN to add the ovr_err output.
module uart_rcv_fc
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
`ifdef UART_RCV_OVERRUN_EN
    ,
    output logic       ovr_err
`endif
);

    localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV - 1);

    rx_state_t   state;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        rx_s;
    logic        fall;

    rx_synch u_synch (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (RX),
        .dout (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
`ifdef UART_RCV_OVERRUN_EN
            ovr_err  <= 1'b0;
`endif
        end else begin
            // Acknowledge first; a same-cycle set below overrides it.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
`ifdef UART_RCV_OVERRUN_EN
                ovr_err <= 1'b0;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        baud_cnt <= HALF_CNT;
                        frm_err  <= 1'b0;
`ifndef UART_RCV_OVERRUN_EN
                        rdy      <= 1'b0;
`endif
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == 12'd0) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            baud_cnt <= FULL_CNT;
                            bit_cnt  <= 3'd0;
                            state    <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == 12'd0) begin
                        shift    <= {rx_s, shift[7:1]};
                        baud_cnt <= FULL_CNT;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == 12'd0) begin
                        if (rx_s) begin
                            rx_data <= shift;
                            rdy     <= 1'b1;
`ifdef UART_RCV_OVERRUN_EN
                            if (rdy && !clr_rdy) begin
                                ovr_err <= 1'b1;
                            end
`endif
                            state   <= IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= BRK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcv_fc.sv
// Self-checking bench for uart_rcv_fc: vector table, corner sequences
// and randomized frames against a frame-level reference model.
module tb_uart_rcv_fc;
    import uart_pkg::*;

    localparam int B   = 32;
    localparam int LAT = (19 * B) / 2 + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
`ifdef UART_RCV_OVERRUN_EN
    logic       ovr_err;
    localparam logic MID_RDY = 1'b1;
`else
    localparam logic MID_RDY = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = -1;
    logic rdy_q = 1'b0;

    // Reference model state, updated per frame / acknowledge
    logic [7:0] m_data = 8'h00;
    logic       m_rdy = 1'b0;
    logic       m_frm = 1'b0;
    logic       m_ovr = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_rdy;
        logic       exp_frm;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    uart_rcv_fc #(.BAUD_DIV(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (rx),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
`ifdef UART_RCV_OVERRUN_EN
        .frm_err(frm_err),
        .ovr_err(ovr_err)
`else
        .frm_err(frm_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy && !rdy_q) rise_cyc = cyc;
        rdy_q = rdy;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rdy"}, 32'(rdy), 32'(m_rdy));
        chk({tag, "_frm"}, 32'(frm_err), 32'(m_frm));
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
`ifdef UART_RCV_OVERRUN_EN
        chk({tag, "_ovr"}, 32'(ovr_err), 32'(m_ovr));
`endif
    endtask

    task automatic wait_bits(input int n);
        repeat (n * B) @(negedge clk);
    endtask

    // Drive one frame; stop=0 holds the line low 5 bit times, then idles.
    task automatic frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        fall_cyc = cyc;
        rise_cyc = -1;
`ifndef UART_RCV_OVERRUN_EN
        m_rdy = 1'b0;
`endif
        m_frm = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
        rx = stop;
        wait_bits(1);
        if (stop) begin
            if (m_rdy) m_ovr = 1'b1;
            m_data = d;
            m_rdy  = 1'b1;
        end else begin
            m_frm = 1'b1;
            wait_bits(4);
            rx = 1'b1;
            wait_bits(1);
        end
    endtask

    task automatic ack();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        int   lat;
        logic got_set;
        logic [7:0] d;
        logic s;

        vecs[0] = '{8'h67, 1'b1, 1'b1, 1'b0, 8'h67};
        vecs[1] = '{8'h73, 1'b1, 1'b1, 1'b0, 8'h73};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h73};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_model("post_reset");

        // First byte and rdy latency from the start-bit edge
        frame(CMD_GO, 1'b1);
        lat = rise_cyc - fall_cyc;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            failures++;
            $display("FAIL latency: got %0d expected %0d", lat, LAT);
        end
        check_model("go");

        // Acknowledge: rdy drops next cycle, data held
        ack();
        chk("ack_rdy", 32'(rdy), 32'd0);
        chk("ack_data", 32'(rx_data), 32'(CMD_GO));

        // Vector table
        for (int i = 0; i < 8; i++) begin
            frame(vecs[i].data, vecs[i].stop);
            chk($sformatf("tab%0d_rdy", i), 32'(rdy), 32'(vecs[i].exp_rdy));
            chk($sformatf("tab%0d_frm", i), 32'(frm_err),
                32'(vecs[i].exp_frm));
            chk($sformatf("tab%0d_data", i), 32'(rx_data),
                32'(vecs[i].exp_data));
            ack();
            chk($sformatf("tab%0d_clr_rdy", i), 32'(rdy), 32'd0);
            chk($sformatf("tab%0d_clr_frm", i), 32'(frm_err), 32'd0);
            chk($sformatf("tab%0d_hold", i), 32'(rx_data),
                32'(vecs[i].exp_data));
        end

        // clr_rdy coincident with the set event: set wins
        got_set = 1'b0;
        fork
            frame(8'h3C, 1'b1);
            begin
                repeat (LAT - 3) @(negedge clk);
                clr_rdy = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (rdy) begin
                        got_set = 1'b1;
                        break;
                    end
                end
                clr_rdy = 1'b0;
            end
        join
        chk("same_cycle_set", 32'(got_set), 32'd1);
        check_model("same_cycle");

        // False start shorter than half a bit
        ack();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        wait_bits(3);
        chk("false_rdy", 32'(rdy), 32'd0);
        chk("false_frm", 32'(frm_err), 32'd0);
        frame(CMD_STOP, 1'b1);
        check_model("after_false");

        // Back-to-back frames, no acknowledge
        ack();
        fork
            begin
                frame(CMD_GO, 1'b1);
                check_model("b2b_first");
                frame(CMD_STOP, 1'b1);
            end
            begin
                wait_bits(12);
                chk("b2b_mid_rdy", 32'(rdy), 32'(MID_RDY));
            end
        join
        check_model("b2b_second");

        // Reset during data bit 4
        ack();
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = CMD_GO[i];
            wait_bits(1);
        end
        rx = 1'b0;
        repeat (B / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        m_data = 8'h00;
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        check_model("midrst");
        wait_bits(12);
        check_model("midrst_quiet");
        frame(CMD_GO, 1'b1);
        check_model("midrst_next");

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            frame(d, s);
            check_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                ack();
                check_model($sformatf("rnd%0d_ack", n));
            end
            repeat ($urandom_range(0, B)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
